// File: rtl/lsu_mem_master.sv
// Load/store initiator for a doubleword-organised data memory: aligned accesses,
// lane extract/extend on loads, read-modify-write for sub-doubleword stores.
// Optional macro LSU_PERF_CNT_EN adds load/store/error completion counters.
module lsu_mem_master #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t            state_q;
  logic [2:0]        off_q;
  logic [2:0]        funct3_q;
  logic              store_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        rd_cnt_q;

  logic              accept;
  logic [2:0]        size_mask;
  logic              req_err;
  logic [5:0]        lane_sh;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] wr_shift;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic [3:0]        lane_lo;
  logic [3:0]        lane_hi;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    size_mask = 3'b111;
    case (req_funct3[1:0])
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  end

  assign req_err = (|(req_addr[2:0] & size_mask)) ||
                   (req_store ? req_funct3[2] : (req_funct3 == 3'b111));

  assign lane_sh  = {off_q, 3'b000};
  assign rd_shift = Read_Data >> lane_sh;
  assign wr_shift = wdata_q << lane_sh;

  always_comb begin
    load_ext = rd_shift;
    case (funct3_q)
      3'b000:  load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  load_ext = {56'd0, rd_shift[7:0]};
      3'b101:  load_ext = {48'd0, rd_shift[15:0]};
      3'b110:  load_ext = {32'd0, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Byte lanes [off, off+size) take the store data; the rest keep the read value.
  assign lane_lo = {1'b0, off_q};
  assign lane_hi = lane_lo + (4'd1 << funct3_q[1:0]);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic be;
      assign be = (4'(gi) >= lane_lo) && (4'(gi) < lane_hi);
      assign merged[8*gi +: 8] = be ? wr_shift[8*gi +: 8] : Read_Data[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      off_q      <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      rd_cnt_q   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      Mem_Addr   <= '0;
      Write_Data <= '0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            off_q    <= req_addr[2:0];
            funct3_q <= req_funct3;
            store_q  <= req_store;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_store && (req_funct3[1:0] == 2'b11)) begin
              state_q    <= WR;
              MemWrite   <= 1'b1;
              Mem_Addr   <= {req_addr[ADDR_W-1:3], 3'b000};
              Write_Data <= req_wdata;
            end else begin
              state_q  <= RD;
              MemRead  <= 1'b1;
              Mem_Addr <= {req_addr[ADDR_W-1:3], 3'b000};
              rd_cnt_q <= LAT_M1;
            end
          end
        end
        RD: begin
          if (rd_cnt_q == 3'd0) begin
            MemRead <= 1'b0;
            if (store_q) begin
              state_q    <= WR;
              MemWrite   <= 1'b1;
              Write_Data <= merged;
            end else begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_ext;
              Mem_Addr   <= '0;
            end
          end else begin
            rd_cnt_q <= rd_cnt_q - 3'd1;
          end
        end
        WR: begin
          state_q    <= RESP;
          MemWrite   <= 1'b0;
          Mem_Addr   <= '0;
          Write_Data <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        default: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else if (state_q == RESP) begin
      if (resp_err)     err_cnt   <= err_cnt + 32'd1;
      else if (store_q) store_cnt <= store_cnt + 32'd1;
      else              load_cnt  <= load_cnt + 32'd1;
    end
  end
`endif

endmodule
